// File: rtl/gpio_input_ctrl.sv
// gpio_input_ctrl: synchronizes, debounces and rising-edge detects button lines and
// serves level/event/count registers on a registered read port. Define GPIO_IRQ_EN for irq.
module gpio_input_ctrl #(
   parameter int WIDTH     = 16,
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gpio_in,
   input  logic             rd_en,
   input  logic [1:0]       rd_addr,
   output logic [15:0]      rd_data,
   output logic             irq
);

   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
   localparam logic [1:0]       ADDR_LEVEL  = 2'd0;
   localparam logic [1:0]       ADDR_EVENTS = 2'd1;
   localparam logic [1:0]       ADDR_COUNT  = 2'd2;
   localparam logic [1:0]       ADDR_FLAG   = 2'd3;

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] stable_reg;
   logic [WIDTH-1:0] stable_next;
   logic [CNT_W-1:0] cnt_reg  [WIDTH];
   logic [CNT_W-1:0] cnt_next [WIDTH];
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] events_reg;
   logic [WIDTH-1:0] events_next;
   logic [15:0]      evcount_reg;
   logic [15:0]      evcount_next;
   logic [15:0]      rd_data_reg;
   logic [15:0]      rd_data_next;
   logic [15:0]      stable_pad;
   logic [15:0]      events_pad;
   logic             new_event;
   logic             rd_events;
   logic             rd_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= gpio_in;
         sync2_reg <= sync1_reg;
      end
   end

   // Per-line debounce: any cycle of agreement restarts the count.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_db
         logic mismatch;
         logic hit;
         assign mismatch        = sync2_reg[gi] ^ stable_reg[gi];
         assign hit             = mismatch && (cnt_reg[gi] == DB_LAST);
         assign cnt_next[gi]    = (!mismatch || hit) ? '0 : cnt_reg[gi] + 1'b1;
         assign stable_next[gi] = hit ? sync2_reg[gi] : stable_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_reg <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_reg[i] <= '0;
      end else begin
         stable_reg <= stable_next;
         for (int i = 0; i < WIDTH; i++) cnt_reg[i] <= cnt_next[i];
      end
   end

   assign rise      = stable_next & ~stable_reg;
   assign new_event = |rise;
   assign rd_events = rd_en && (rd_addr == ADDR_EVENTS);
   assign rd_count  = rd_en && (rd_addr == ADDR_COUNT);

   // A press landing on the clearing read survives the clear.
   always_comb begin
      events_next = events_reg | rise;
      if (rd_events) events_next = rise;
   end

   always_comb begin
      evcount_next = evcount_reg;
      if (rd_count)
         evcount_next = {15'b0, new_event};
      else if (new_event && (evcount_reg != 16'hFFFF))
         evcount_next = evcount_reg + 16'd1;
   end

   generate
      for (gi = 0; gi < 16; gi++) begin : g_pad
         if (gi < WIDTH) begin : g_used
            assign stable_pad[gi] = stable_reg[gi];
            assign events_pad[gi] = events_reg[gi];
         end else begin : g_zero
            assign stable_pad[gi] = 1'b0;
            assign events_pad[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      rd_data_next = rd_data_reg;
      if (rd_en) begin
         case (rd_addr)
            ADDR_LEVEL:  rd_data_next = stable_pad;
            ADDR_EVENTS: rd_data_next = events_pad;
            ADDR_COUNT:  rd_data_next = evcount_reg;
            ADDR_FLAG:   rd_data_next = {15'b0, |events_reg};
            default:     rd_data_next = rd_data_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         events_reg  <= '0;
         evcount_reg <= '0;
         rd_data_reg <= '0;
      end else begin
         events_reg  <= events_next;
         evcount_reg <= evcount_next;
         rd_data_reg <= rd_data_next;
      end
   end

   assign rd_data = rd_data_reg;

`ifdef GPIO_IRQ_EN
   logic irq_reg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_reg <= 1'b0;
      else     irq_reg <= |events_reg;
   end
   assign irq = irq_reg;
`else
   assign irq = 1'b0;
`endif

endmodule
